// File: rtl/exposure_timer_pkg.sv
// Shared definitions for the exposure timer: FSM state encoding and mode constants.
package exposure_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/exposure_timer_tick_prescaler.sv
// Divides Clk into time units; Tick is high during the last cycle of each unit.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clr,
    input  logic En,
    output logic Tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            cnt <= '0;
        else if (Clr)
            cnt <= '0;
        else if (En)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign Tick = En && (cnt == LAST);

endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: counts a clamped exposure time in prescaled units, pulses Ovf on
// expiry, with abort and one-shot / auto-restart modes.
module exposure_timer
    import exposure_timer_pkg::*;
#(
    parameter int TIME_W   = 5,
    parameter int PRESCALE = 1,
    parameter int MIN_TIME = 2,
    parameter int MAX_TIME = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Mode,
    input  logic [TIME_W-1:0] EX_time,
    output logic              Busy,
    output logic              Ovf,
    output logic [TIME_W-1:0] Count,
    output logic [TIME_W-1:0] Ex_latched
);

    localparam logic [TIME_W-1:0] MIN_T = TIME_W'(MIN_TIME);
    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] ONE   = TIME_W'(1);

    state_t            state_q, state_d;
    logic [TIME_W-1:0] count_q, count_d;
    logic [TIME_W-1:0] ex_q, ex_d;
    logic              ovf_q, ovf_d;
    logic [TIME_W-1:0] t_clamp;
    logic              tick;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (state_q == ST_IDLE),
        .En    (state_q == ST_RUN),
        .Tick  (tick)
    );

    always_comb begin
        t_clamp = EX_time;
        if (EX_time < MIN_T)
            t_clamp = MIN_T;
        else if (EX_time > MAX_T)
            t_clamp = MAX_T;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ex_d    = ex_q;
        ovf_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    count_d = t_clamp;
                    ex_d    = t_clamp;
                end
            end
            ST_RUN: begin
                // Abort wins over an expiry landing on the same edge.
                if (Abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (tick && count_q != '0) begin
                    count_d = count_q - 1'b1;
                    if (count_q == ONE) begin
                        ovf_d = 1'b1;
                        if (Mode == MODE_AUTO) begin
                            count_d = t_clamp;
                            ex_d    = t_clamp;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ex_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ex_q    <= ex_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Busy       = (state_q == ST_RUN);
    assign Ovf        = ovf_q;
    assign Count      = count_q;
    assign Ex_latched = ex_q;

endmodule

// File: tb/tb_exposure_timer.sv
// Directed bench for exposure_timer: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_exposure_timer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start, Abort, Mode;
    logic [4:0] EX_time;

    logic       busy1, ovf1, busy4, ovf4;
    logic [4:0] count1, exl1, count4, exl4;

    int vectors = 0;
    int errors  = 0;

    always #5 Clk = ~Clk;

    exposure_timer #(.TIME_W(5), .PRESCALE(1), .MIN_TIME(2), .MAX_TIME(30)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode),
        .EX_time(EX_time), .Busy(busy1), .Ovf(ovf1), .Count(count1), .Ex_latched(exl1)
    );

    exposure_timer #(.TIME_W(5), .PRESCALE(4), .MIN_TIME(2), .MAX_TIME(30)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode),
        .EX_time(EX_time), .Busy(busy4), .Ovf(ovf4), .Count(count4), .Ex_latched(exl4)
    );

    task automatic chk(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_pulse(input logic [4:0] t);
        EX_time = t;
        Start   = 1'b1;
        step();
        Start   = 1'b0;
    endtask

    // Edges from now until Ovf is seen; lim+1 on timeout.
    task automatic wait_ovf(input bit sel, input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((sel ? ovf4 : ovf1) == 1'b0) && n <= lim);
    endtask

    int  n;
    bit  seen;

    initial begin
        Reset = 1'b0; Start = 1'b0; Abort = 1'b0; Mode = 1'b0; EX_time = '0;
        #2;
        chk("rst_busy", busy1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_count", count1, 0);
        chk("rst_exl", exl1, 0);
        #1 Reset = 1'b1;
        step();

        // one-shot countdown from 10
        start_pulse(5'd10);
        chk("t1_count_k", count1, 10);
        chk("t1_exl", exl1, 10);
        chk("t1_busy_k", busy1, 1);
        for (int i = 9; i >= 1; i--) begin
            step();
            chk("t1_count", count1, i);
            chk("t1_ovf_early", ovf1, 0);
        end
        step();
        chk("t1_ovf", ovf1, 1);
        chk("t1_busy_end", busy1, 0);
        chk("t1_count_end", count1, 0);
        step();
        chk("t1_ovf_once", ovf1, 0);

        // clamping
        start_pulse(5'd0);
        chk("t2_exl_min", exl1, 2);
        wait_ovf(1'b0, 40, n);
        chk("t2_lat_min", n, 2);
        step();
        start_pulse(5'd31);
        chk("t2_exl_max", exl1, 30);
        wait_ovf(1'b0, 40, n);
        chk("t2_lat_max", n, 30);
        chk("t2_busy_end", busy1, 0);
        step();

        // abort mid-run
        start_pulse(5'd10);
        repeat (6) step();
        chk("t3_count4", count1, 4);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("t3_busy", busy1, 0);
        chk("t3_count", count1, 0);
        seen = (ovf1 == 1'b1);
        repeat (15) begin
            step();
            if (ovf1) seen = 1'b1;
        end
        chk("t3_no_ovf", int'(seen), 0);

        // abort on the expiry edge
        start_pulse(5'd3);
        step(); step();
        chk("t3b_count1", count1, 1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("t3b_ovf", ovf1, 0);
        chk("t3b_busy", busy1, 0);
        step();
        chk("t3b_ovf_after", ovf1, 0);

        // auto-restart with EX_time change mid-run
        Mode = 1'b1;
        start_pulse(5'd3);
        chk("t4_exl3", exl1, 3);
        EX_time = 5'd5;
        step(); step();
        chk("t4_count1", count1, 1);
        step();
        chk("t4_ovf3", ovf1, 1);
        chk("t4_reload", count1, 5);
        chk("t4_exl5", exl1, 5);
        chk("t4_busy", busy1, 1);
        Mode = 1'b0;
        repeat (4) step();
        chk("t4_count_b", count1, 1);
        chk("t4_ovf_gap", ovf1, 0);
        step();
        chk("t4_ovf8", ovf1, 1);
        chk("t4_busy_end", busy1, 0);
        chk("t4_count_end", count1, 0);

        // bring both instances to IDLE before the prescaled test
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        step();
        chk("t5_idle4", busy4, 0);

        // PRESCALE=4, T=2 -> Ovf 8 edges after Start; Start mid-run ignored
        start_pulse(5'd2);
        chk("t5_count_k", count4, 2);
        step(); step(); step();
        chk("t5_count_k3", count4, 2);
        step();
        chk("t5_count_k4", count4, 1);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("t5_retrig", count4, 1);
        step(); step();
        chk("t5_ovf_early", ovf4, 0);
        step();
        chk("t5_ovf", ovf4, 1);
        chk("t5_busy_end", busy4, 0);
        chk("t5_count_end", count4, 0);
        repeat (3) step();

        // asynchronous reset mid-run
        start_pulse(5'd10);
        repeat (5) step();
        chk("t6_count5", count1, 5);
        #2 Reset = 1'b0;
        #1;
        chk("t6_busy", busy1, 0);
        chk("t6_count", count1, 0);
        chk("t6_exl", exl1, 0);
        chk("t6_ovf", ovf1, 0);
        chk("t6_busy4", busy4, 0);
        #3 Reset = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            step();
            if (ovf1 || busy1) seen = 1'b1;
        end
        chk("t6_quiet", int'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
